exc_arbiter: RTL and testbench

Exception request arbiter directly upstream of the CP0 block. Each cycle it collects the synchronous exception strobes (syscall, break, teq trap) and an asynchronous external interrupt, qualifies them against the CP0 status register, and drives CP0's `exception`, `cause` and `eret` inputs. It also tracks the handler nesting depth, which is bounded by the 5-bit status shift that CP0 performs on each exception entry.

---
 rtl/exc_arbiter.sv | 98 +++++++++
 tb/tb_exc_arbiter.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/exc_arbiter.sv
// Exception request arbiter feeding CP0: qualifies instruction/interrupt exceptions
// against status, tracks handler nesting depth. Define EXC_IRQ_EN to include the irq path.
module exc_arbiter #(
  parameter int MAX_DEPTH = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        syscall,
  input  logic        brk,
  input  logic        teq,
  input  logic        eret_in,
  input  logic        irq,
  input  logic [31:0] status,
  output logic        exception,
  output logic [3:0]  cause,
  output logic        eret,
  output logic [2:0]  depth,
  output logic        irq_pending,
  output logic        nest_ovf
);

  localparam logic [2:0] DMAX   = 3'(MAX_DEPTH);
  localparam logic [3:0] EC_SYS = 4'b1000;
  localparam logic [3:0] EC_BRK = 4'b1001;
  localparam logic [3:0] EC_TEQ = 4'b1101;
  localparam logic [3:0] EC_IRQ = 4'b0000;

  logic       cand;     // some enabled candidate exists this cycle
  logic       sel_irq;  // that candidate is the pending interrupt
  logic [3:0] sel_code;
  logic       at_max;

  always_comb begin
    cand     = 1'b0;
    sel_irq  = 1'b0;
    sel_code = EC_IRQ;
    if (status[0]) begin
      if (teq && status[3]) begin
        cand = 1'b1; sel_code = EC_TEQ;
      end else if (brk && status[2]) begin
        cand = 1'b1; sel_code = EC_BRK;
      end else if (syscall && status[1]) begin
        cand = 1'b1; sel_code = EC_SYS;
      end else if (irq_pending && status[4]) begin
        cand = 1'b1; sel_irq = 1'b1; sel_code = EC_IRQ;
      end
    end
  end

  // Full depth suppresses the exception entirely; CP0's status shift has no room left.
  assign at_max    = (depth >= DMAX);
  assign exception = cand && !at_max;
  assign cause     = exception ? sel_code : 4'b0000;
  assign eret      = eret_in && (depth != 3'd0) && !exception;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      depth    <= 3'd0;
      nest_ovf <= 1'b0;
    end else begin
      if (exception)
        depth <= depth + 3'd1;
      else if (eret)
        depth <= depth - 3'd1;
      if (cand && at_max)
        nest_ovf <= 1'b1;
    end
  end

`ifdef EXC_IRQ_EN
  logic irq_s1, irq_s2;
  logic unused_ok;

  // Clear beats set: a still-high irq re-arms pending one edge after being serviced.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      irq_s1      <= 1'b0;
      irq_s2      <= 1'b0;
      irq_pending <= 1'b0;
    end else begin
      irq_s1 <= irq;
      irq_s2 <= irq_s1;
      if (exception && sel_irq)
        irq_pending <= 1'b0;
      else if (irq_s2)
        irq_pending <= 1'b1;
    end
  end

  assign unused_ok = ^status[31:5];
`else
  logic unused_ok;

  assign irq_pending = 1'b0;
  assign unused_ok   = ^{status[31:5], irq, sel_irq};
`endif

endmodule

// File: tb/tb_exc_arbiter.sv
// Randomized + directed bench for exc_arbiter against a rule-level reference model.
// Follows the EXC_IRQ_EN build option of the design.
module tb_exc_arbiter;
  localparam int MAXD = 6;

  logic        clk = 1'b0, rst = 1'b0;
  logic        syscall = 1'b0, brk = 1'b0, teq = 1'b0, eret_in = 1'b0, irq = 1'b0;
  logic [31:0] status = '0;
  logic        exception, eret, irq_pending, nest_ovf;
  logic [3:0]  cause;
  logic [2:0]  depth;

  exc_arbiter #(.MAX_DEPTH(MAXD)) dut (
    .clk(clk), .rst(rst), .syscall(syscall), .brk(brk), .teq(teq),
    .eret_in(eret_in), .irq(irq), .status(status), .exception(exception),
    .cause(cause), .eret(eret), .depth(depth), .irq_pending(irq_pending),
    .nest_ovf(nest_ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int m_depth = 0;
  bit m_pend = 0, m_ovf = 0;
  bit irq_hist[$];  // irq levels seen at recent rising edges, newest last

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_depth = 0; m_pend = 0; m_ovf = 0;
    irq_hist.delete();
  endtask

  // Called #1 after a rising edge; returns #1 after the next one.
  task automatic cyc(bit sc, bit bk, bit tq, bit er, bit iq, logic [31:0] st);
    bit reqs[4];
    bit ens[4];
    int codes[4];
    bit hit;
    int sel;
    bit e_exc, e_eret;
    int e_cause;
    syscall = sc; brk = bk; teq = tq; eret_in = er; irq = iq; status = st;
    @(negedge clk);
    reqs  = '{tq, bk, sc, m_pend};
    ens   = '{st[3], st[2], st[1], st[4]};
    codes = '{13, 9, 8, 0};
    hit = 0; sel = 0;
    for (int i = 0; i < 4; i++)
      if (!hit && st[0] && reqs[i] && ens[i]) begin hit = 1; sel = i; end
    e_exc   = hit && (m_depth < MAXD);
    e_cause = e_exc ? codes[sel] : 0;
    e_eret  = er && (m_depth > 0) && !e_exc;
    chk("exception", exception, e_exc);
    chk("cause", cause, e_cause);
    chk("eret", eret, e_eret);
    chk("depth", depth, m_depth);
    chk("irq_pending", irq_pending, m_pend);
    chk("nest_ovf", nest_ovf, m_ovf);
    if (hit && m_depth == MAXD) m_ovf = 1;
    if (e_exc) m_depth++;
    else if (e_eret) m_depth--;
`ifdef EXC_IRQ_EN
    // pending sets from the irq level captured two rising edges before this one
    if (e_exc && sel == 3) m_pend = 0;
    else if (irq_hist.size() >= 2 && irq_hist[irq_hist.size()-2]) m_pend = 1;
`endif
    irq_hist.push_back(iq);
    if (irq_hist.size() > 4) void'(irq_hist.pop_front());
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    syscall = 0; brk = 0; teq = 0; eret_in = 0; irq = 0; status = '0;
    rst = 0;
    model_reset();
    #1;
    chk("rst_depth", depth, 0);
    chk("rst_pending", irq_pending, 0);
    chk("rst_ovf", nest_ovf, 0);
    chk("rst_exception", exception, 0);
    chk("rst_cause", cause, 0);
    chk("rst_eret", eret, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1;
  endtask

  initial begin
    @(posedge clk); #1;
    do_reset();

    // single syscall
    cyc(1,0,0,0,0, 32'h0000000F);
    chk("t1_depth", depth, 1);

    // syscall disabled, eret at depth 0 dropped
    do_reset();
    cyc(1,0,0,0,0, 32'h00000001);
    chk("t2_depth", depth, 0);
    cyc(0,0,0,1,0, 32'h00000001);
    chk("t2_depth_eret", depth, 0);

    // irq held off by teq, then taken
    do_reset();
    repeat (5) cyc(0,0,1,0,1, 32'h0000001F);
`ifdef EXC_IRQ_EN
    chk("t3_pending_held", irq_pending, 1);
`endif
    cyc(0,0,0,0,0, 32'h0000001F);
    chk("t3_pending_clr", irq_pending, 0);
    repeat (8) cyc(0,0,0,1,0, 32'h0000001F);

    // nesting overflow then unwind
    do_reset();
    repeat (7) cyc(1,0,0,0,0, 32'h0000000F);
    chk("t4_depth_full", depth, MAXD);
    chk("t4_ovf", nest_ovf, 1);
    repeat (6) cyc(0,0,0,1,0, 32'h0000000F);
    chk("t4_depth_empty", depth, 0);
    chk("t4_ovf_sticky", nest_ovf, 1);

    // asynchronous reset mid-cycle
    do_reset();
    repeat (2) cyc(1,0,0,0,0, 32'h0000000F);
    repeat (4) cyc(0,0,0,0,1, 32'h0000000F);
    chk("t5_depth_pre", depth, 2);
    chk("t5_pending_pre", irq_pending, m_pend);
    #2 rst = 0;
    model_reset();
    #1;
    chk("t5_depth", depth, 0);
    chk("t5_pending", irq_pending, 0);
    chk("t5_ovf", nest_ovf, 0);
    chk("t5_exception", exception, 0);
    irq = 0;
    @(posedge clk); #1 rst = 1;

    // steady irq level with all enables
    do_reset();
    repeat (10) cyc(0,0,0,0,1, 32'h0000001F);
`ifndef EXC_IRQ_EN
    chk("t6_depth_noirq", depth, 0);
`endif

    // randomized traffic
    do_reset();
    begin
      bit cur_irq = 0;
      for (int n = 0; n < 3000; n++) begin
        int r;
        bit sc, bk, tq, er;
        logic [31:0] st;
        st = $urandom;
        st[0] = ($urandom_range(0, 9) < 8);
        r = $urandom_range(0, 9);
        sc = (r <= 1); bk = (r == 2); tq = (r == 3); er = (r >= 4 && r <= 6);
        if (r == 7) begin sc = $urandom; bk = $urandom; tq = $urandom; end
        if ($urandom_range(0, 7) == 0) cur_irq = ~cur_irq;
        cyc(sc, bk, tq, er, cur_irq, st);
        if ($urandom_range(0, 499) == 0) do_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
